// File: rtl/jump.sv
// Next-PC selection for the fetch stage: sequential, stall hold, B/CALL/RET redirects.
// Optional 8-entry return-address stack, enabled by defining JUMP_RAS_EN.
`ifndef JUMP_OPCODES_SVH
`define JUMP_OPCODES_SVH
`define ADD  4'h0
`define SUB  4'h1
`define NAND 4'h2
`define XOR  4'h3
`define INC  4'h4
`define SRA  4'h5
`define SRL  4'h6
`define SLL  4'h7
`define SW   4'h8
`define LW   4'h9
`define LHB  4'hA
`define LLB  4'hB
`define B    4'hC
`define CALL 4'hD
`define RET  4'hE
`endif

module jump (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] nxt_pc,
  input  logic [15:0] pc,
  input  logic [15:0] ex_instr,
  input  logic        branch,
  input  logic [15:0] if_pc,
  input  logic [15:0] id_pc,
  input  logic        control_hazard,
  input  logic        data_hazard,
  input  logic [15:0] ret_addr,
  output logic        flush
);

  logic [3:0]  w_op;
  logic        w_valid;
  logic        w_is_b;
  logic        w_is_call;
  logic        w_is_ret;
  logic [15:0] w_ret_target;
  logic [15:0] w_b_target;
  logic [15:0] w_call_target;

  assign w_op          = ex_instr[15:12];
  assign w_valid       = !control_hazard;
  assign w_is_b        = w_valid && (w_op == `B) && branch;
  assign w_is_call     = w_valid && (w_op == `CALL);
  assign w_is_ret      = w_valid && (w_op == `RET);
  assign w_b_target    = pc + 16'd2 + {{8{ex_instr[7]}}, ex_instr[7:0]};
  assign w_call_target = {pc[15:12], ex_instr[11:0]};

  always_comb begin
    nxt_pc = pc + 16'd1;
    flush  = 1'b0;
    if (w_is_b) begin
      nxt_pc = w_b_target;
      flush  = 1'b1;
    end else if (w_is_call) begin
      nxt_pc = w_call_target;
      flush  = 1'b1;
    end else if (w_is_ret) begin
      nxt_pc = w_ret_target;
      flush  = 1'b1;
    end else if (data_hazard) begin
      nxt_pc = pc;
    end
  end

`ifdef JUMP_RAS_EN
  // Circular stack: r_ptr is the next write slot, so a push when full lands on the oldest entry.
  logic [15:0] r_stack [0:7];
  logic [2:0]  r_ptr;
  logic [3:0]  r_count;
  logic [2:0]  w_top_idx;
  logic        w_unused_ok;

  assign w_top_idx    = r_ptr - 3'd1;
  assign w_ret_target = (r_count != 4'd0) ? r_stack[w_top_idx] : ret_addr;
  assign w_unused_ok  = ^if_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= 3'd0;
      r_count <= 4'd0;
    end else if (w_is_call) begin
      r_stack[r_ptr] <= id_pc + 16'd1;
      r_ptr          <= r_ptr + 3'd1;
      if (r_count != 4'd8) begin
        r_count <= r_count + 4'd1;
      end
    end else if (w_is_ret && (r_count != 4'd0)) begin
      r_ptr   <= r_ptr - 3'd1;
      r_count <= r_count - 4'd1;
    end
  end
`else
  logic w_unused_ok;

  assign w_ret_target = ret_addr;
  assign w_unused_ok  = ^{clk, rst, if_pc, id_pc};
`endif

endmodule

// File: tb/tb_jump.sv
// Directed bench for jump: per-cycle comparison against a queue-based model plus literal checks.
`ifndef JUMP_OPCODES_SVH
`define JUMP_OPCODES_SVH
`define ADD  4'h0
`define SUB  4'h1
`define NAND 4'h2
`define XOR  4'h3
`define INC  4'h4
`define SRA  4'h5
`define SRL  4'h6
`define SLL  4'h7
`define SW   4'h8
`define LW   4'h9
`define LHB  4'hA
`define LLB  4'hB
`define B    4'hC
`define CALL 4'hD
`define RET  4'hE
`endif

module tb_jump;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] nxt_pc;
  logic [15:0] pc;
  logic [15:0] ex_instr;
  logic        branch;
  logic [15:0] if_pc;
  logic [15:0] id_pc;
  logic        control_hazard;
  logic        data_hazard;
  logic [15:0] ret_addr;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ras_q[$];
  logic [3:0]  non_ctl [12] = '{`ADD, `SUB, `NAND, `XOR, `INC, `SRA,
                                 `SRL, `SLL, `SW, `LW, `LHB, `LLB};

  jump dut (
    .clk(clk), .rst(rst), .nxt_pc(nxt_pc), .pc(pc), .ex_instr(ex_instr),
    .branch(branch), .if_pc(if_pc), .id_pc(id_pc), .control_hazard(control_hazard),
    .data_hazard(data_hazard), .ret_addr(ret_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pc=%h instr=%h)", name, got, exp, pc, ex_instr);
    end
  endtask

  // Model: next PC from the architectural rules, return stack as a bounded queue.
  always @(negedge clk) begin
    logic [15:0] e_pc;
    logic        e_fl;
    logic [3:0]  op;
    int          off;
    op   = ex_instr[15:12];
    e_fl = 1'b1;
    off  = ex_instr[7] ? int'(ex_instr[7:0]) - 256 : int'(ex_instr[7:0]);
    if (!control_hazard && op == `B && branch)
      e_pc = 16'((int'(pc) + 2 + off) % 65536);
    else if (!control_hazard && op == `CALL)
      e_pc = (pc & 16'hF000) | (ex_instr & 16'h0FFF);
    else if (!control_hazard && op == `RET)
      e_pc = (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : ret_addr;
    else begin
      e_fl = 1'b0;
      e_pc = data_hazard ? pc : 16'((int'(pc) + 1) % 65536);
    end
    chk("model_nxt_pc", nxt_pc, e_pc);
    chk("model_flush", {15'd0, flush}, {15'd0, e_fl});
  end

`ifdef JUMP_RAS_EN
  always @(posedge clk) begin
    if (rst) ras_q.delete();
    else if (!control_hazard && ex_instr[15:12] == `CALL) begin
      ras_q.push_back(id_pc + 16'd1);
      if (ras_q.size() > 8) void'(ras_q.pop_front());
    end else if (!control_hazard && ex_instr[15:12] == `RET && ras_q.size() > 0)
      void'(ras_q.pop_back());
  end
`endif

  task automatic step(input string name, input logic [15:0] e_pc, input logic e_fl);
    @(negedge clk);
    chk({name, "_pc"}, nxt_pc, e_pc);
    chk({name, "_flush"}, {15'd0, flush}, {15'd0, e_fl});
    $display("txn %-12s pc=%h instr=%h br=%b ch=%b dh=%b -> nxt_pc=%h flush=%b",
             name, pc, ex_instr, branch, control_hazard, data_hazard, nxt_pc, flush);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] p, input logic [15:0] ins, input logic br,
                        input logic ch, input logic dh);
    pc = p; ex_instr = ins; branch = br; control_hazard = ch; data_hazard = dh;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(16'h0000, {`ADD, 12'h000}, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step("reset", 16'h0001, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    if_pc = 16'h0000; id_pc = 16'h0000; ret_addr = 16'h0000;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < 2; b++) begin
        set_in(16'hB1AB, {non_ctl[i], 12'h3AB}, b[0], 1'b0, 1'b0);
        step("nonctl", 16'hB1AC, 1'b0);
      end
    end

    set_in(16'h1055, {`B, 4'h0, 8'h00}, 1'b0, 1'b0, 1'b0); step("b_nt", 16'h1056, 1'b0);
    set_in(16'h1055, {`B, 4'h0, 8'h00}, 1'b1, 1'b0, 1'b0); step("b_t0", 16'h1057, 1'b1);
    set_in(16'h0055, {`B, 4'h0, 8'hAB}, 1'b1, 1'b0, 1'b0); step("b_neg", 16'h0002, 1'b1);
    set_in(16'h0055, {`B, 4'h0, 8'hAB}, 1'b1, 1'b1, 1'b0); step("b_squash", 16'h0056, 1'b0);
    set_in(16'h0055, {`B, 4'h0, 8'h10}, 1'b1, 1'b0, 1'b1); step("b_stall", 16'h0067, 1'b1);

    id_pc = 16'h0700;
    set_in(16'hC0DA, {`CALL, 12'h000}, 1'b0, 1'b0, 1'b0); step("call_b0", 16'hC000, 1'b0 | 1'b1);
    set_in(16'hC0DA, {`CALL, 12'h000}, 1'b1, 1'b0, 1'b0); step("call_b1", 16'hC000, 1'b1);
    set_in(16'hC0DA, {`CALL, 12'h000}, 1'b0, 1'b1, 1'b0); step("call_sq", 16'hC0DB, 1'b0);

    do_reset();
    ret_addr = 16'h1234;
    set_in(16'h0200, {`RET, 12'h000}, 1'b0, 1'b0, 1'b0); step("ret_empty", 16'h1234, 1'b1);
    set_in(16'h0100, {`ADD, 12'h000}, 1'b0, 1'b0, 1'b1); step("stall", 16'h0100, 1'b0);
    set_in(16'hFFFF, {`ADD, 12'h000}, 1'b0, 1'b0, 1'b0); step("wrap", 16'h0000, 1'b0);

`ifdef JUMP_RAS_EN
    do_reset();
    id_pc = 16'h0040;
    set_in(16'h0041, {`CALL, 12'h500}, 1'b0, 1'b0, 1'b0); step("ras_call", 16'h0500, 1'b1);
    set_in(16'h0500, {`RET, 12'h000}, 1'b0, 1'b0, 1'b0); step("ras_ret", 16'h0041, 1'b1);
    set_in(16'h0041, {`RET, 12'h000}, 1'b0, 1'b0, 1'b0); step("ras_empty", 16'h1234, 1'b1);
    for (int k = 0; k < 9; k++) begin
      id_pc = 16'h0100 + 16'(k);
      set_in(16'h2000, {`CALL, 12'h800}, 1'b0, 1'b0, 1'b0); step("ras_push", 16'h2800, 1'b1);
    end
    ret_addr = 16'hDEAD;
    for (int k = 0; k < 8; k++) begin
      set_in(16'h2800, {`RET, 12'h000}, 1'b0, 1'b0, 1'b0);
      step("ras_pop", 16'h0109 - 16'(k), 1'b1);
    end
    set_in(16'h2800, {`RET, 12'h000}, 1'b0, 1'b0, 1'b0); step("ras_drained", 16'hDEAD, 1'b1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump.md
JUMP -- requirements
Module: jump

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port nxt_pc, output, 16 bits: PC to fetch next cycle (combinational).
REQ-004 SHALL have port pc, input, 16 bits: current fetch PC.
REQ-005 SHALL have port ex_instr, input, 16 bits: instruction in EX; [15:12] opcode, [7:0] B offset, [11:0] CALL target.
REQ-006 SHALL have port branch, input, 1 bit: B condition true, from EX flags.
REQ-007 SHALL have port if_pc, input, 16 bits: PC of the instruction in the IF/ID latch; unused by next-PC math.
REQ-008 SHALL have port id_pc, input, 16 bits: PC of the instruction in EX; used for the return-stack push.
REQ-009 SHALL have port control_hazard, input, 1 bit: 1 = EX instruction squashed; treat it as non-control.
REQ-010 SHALL have port data_hazard, input, 1 bit: 1 = fetch stall request.
REQ-011 SHALL have port ret_addr, input, 16 bits: RET target from the register file.
REQ-012 SHALL have port flush, output, 1 bit: 1 when a redirect is taken this cycle.
REQ-013 SHALL use the opcode macros from the shared opcode header (ADD, SUB, NAND, XOR, INC, SRA, SRL, SLL, SW, LW, LHB, LLB, B, CALL, RET); no local encodings.

Function
REQ-014 SHALL define valid = !control_hazard.
REQ-015 SHALL set redirect target = pc + 2 + sign_extend(ex_instr[7:0]) for valid B with branch=1, modulo 2^16.
REQ-016 SHALL set redirect target = {pc[15:12], ex_instr[11:0]} for valid CALL, regardless of branch.
REQ-017 SHALL set redirect target = the popped stack entry (REQ-025) or ret_addr for valid RET, regardless of branch.
REQ-018 SHALL set nxt_pc as follows:
- redirect taken: redirect target; redirect overrides data_hazard.
- else data_hazard=1: pc (hold).
- else: pc + 1, modulo 2^16 (FFFF -> 0000).
REQ-019 SHALL treat every opcode except B, CALL and RET as non-control; branch is ignored for these.
REQ-020 SHALL treat B with branch=0 as non-redirect: nxt_pc = pc+1 (or pc under stall).
REQ-021 SHALL set flush=1 exactly when a redirect is taken; flush=0 otherwise.
REQ-022 SHALL make nxt_pc and flush purely combinational from their inputs and stack state, with zero latency.

Reset
REQ-023 SHALL clear the return-stack count and pointer to 0 on rst=1 at a clk edge; rst has priority over push/pop in that cycle.
REQ-024 SHALL leave nxt_pc and flush combinational during reset; reset does not alter them.

Configuration
REQ-025 SHALL implement an 8-entry return-address stack when JUMP_RAS_EN is defined:
- Valid CALL pushes id_pc+1 at the clk edge.
- Valid RET pops at the clk edge; nxt_pc = top entry combinationally.
- RET on an empty stack uses ret_addr and leaves the count at 0.
- Push when full overwrites the oldest entry; count stays 8.
REQ-026 SHALL, without JUMP_RAS_EN, omit the stack and use ret_addr for RET; clk and rst then have no effect.

Verification
REQ-027 SHALL check: pc=B1AB, ex_instr=ADD, branch 0 then 1 -> nxt_pc=B1AC both; same pattern for SUB, NAND, XOR, INC, SRA, SRL, SLL, SW, LW, LHB, LLB; flush=0.
REQ-028 SHALL check: pc=1055, B offset 00, branch=0 -> 1056; branch=1 -> 1057, flush=1; pc=0055, offset AB, branch=1 -> 0002.
REQ-029 SHALL check: pc=C0DA, CALL target 000, branch 0 and 1 -> nxt_pc=C000; control_hazard=1 -> C0DB.
REQ-030 SHALL check: no macro, RET with ret_addr=1234 -> nxt_pc=1234; data_hazard=1 with ADD at pc=0100 -> nxt_pc=0100, flush=0.
REQ-031 SHALL check with JUMP_RAS_EN: reset, CALL with id_pc=0040, then RET -> nxt_pc=0041; a second RET (empty) -> ret_addr; 9 pushes then 8 pops return the newest 8 entries in LIFO order.
REQ-032 SHALL check: pc=FFFF, ADD -> nxt_pc=0000.
